// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: ExtType one-hot bit
// indices, FSM state encoding, SRAM size codes and the request-size helper.
package mem_access_stage_pkg;

  localparam int EXT_W    = 9;
  localparam int EXT_NONE = 0;
  localparam int EXT_LW   = 1;
  localparam int EXT_LH   = 2;
  localparam int EXT_LHU  = 3;
  localparam int EXT_LB   = 4;
  localparam int EXT_LBU  = 5;
  localparam int EXT_LWL  = 6;
  localparam int EXT_LWR  = 7;
  localparam int EXT_RSV  = 8;  // reserved, behaves as LW

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Stores size by strobe count; loads size by extension type.
  // A bubble (no strobes, no ext bit) therefore reads as a word access.
  function automatic logic [1:0] req_size(input logic [3:0]       wstrb,
                                          input logic [EXT_W-1:0] ext);
    logic [1:0] sz;
    sz = SIZE_WORD;
    if (wstrb != 4'b0000) begin
      case (wstrb)
        4'b0001, 4'b0010, 4'b0100, 4'b1000:                   sz = SIZE_BYTE;
        4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1010, 4'b1100: sz = SIZE_HALF;
        default:                                              sz = SIZE_WORD;
      endcase
    end else if (ext[EXT_LB] | ext[EXT_LBU]) begin
      sz = SIZE_BYTE;
    end else if (ext[EXT_LH] | ext[EXT_LHU]) begin
      sz = SIZE_HALF;
    end
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// load_extend_unit: combinational load-data formatter. Selects and extends
// the addressed byte/halfword, or (with MEM_UNALIGNED_LWLR_EN defined)
// merges the word with the old rt value for LWL/LWR.
module load_extend_unit
  import mem_access_stage_pkg::*;
(
  input  logic [31:0]      rdata,
  input  logic [1:0]       addr_lo,
  input  logic [EXT_W-1:0] ext_type,
  input  logic [31:0]      rt_old,
  output logic [31:0]      result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] merge_res;
  logic        merge_sel;

  // NONE, LW and reserved all fall through to the raw word.
  logic unused_ext;
  assign unused_ext = ^{ext_type[EXT_RSV], ext_type[EXT_LW], ext_type[EXT_NONE]};

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

`ifdef MEM_UNALIGNED_LWLR_EN
  // Little-endian LWL fills the upper bytes from the word, LWR the lower ones;
  // the remaining bytes keep the old rt contents.
  assign merge_sel = ext_type[EXT_LWL] | ext_type[EXT_LWR];
  assign merge_res = ext_type[EXT_LWL]
    ? ((rdata << {~addr_lo, 3'b000}) | (rt_old & ~(32'hFFFF_FFFF << {~addr_lo, 3'b000})))
    : ((rdata >> {addr_lo, 3'b000})  | (rt_old & ~(32'hFFFF_FFFF >> {addr_lo, 3'b000})));
`else
  // Without merge support LWL/LWR are plain word loads.
  logic unused_merge;
  assign unused_merge = ^{rt_old, ext_type[EXT_LWL], ext_type[EXT_LWR]};
  assign merge_sel    = 1'b0;
  assign merge_res    = rdata;
`endif

  // Pick the load result by extension type; default is the word as read.
  always_comb begin
    result = rdata;
    if (ext_type[EXT_LB])       result = {{24{byte_sel[7]}}, byte_sel};
    else if (ext_type[EXT_LBU]) result = {24'h0, byte_sel};
    else if (ext_type[EXT_LH])  result = {{16{half_sel[15]}}, half_sel};
    else if (ext_type[EXT_LHU]) result = {16'h0, half_sel};
    else if (merge_sel)         result = merge_res;
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: M pipeline register, one data-SRAM transaction per
// memory instruction, load formatting and the M-stage forwarding bundle.
// Optional feature macro: MEM_UNALIGNED_LWLR_EN (LWL/LWR merge support).
//
// SRAM handshake: data_sram_req is held high with stable request fields
// until a cycle where data_sram_addr_ok is also high (request accepted on
// that edge). Exactly one data_sram_data_ok follows for each accepted
// request; rdata is valid only in the data_ok cycle. data_ok is only
// meaningful in DATA/DRAIN.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int T_W    = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              exp_flush,
  input  logic [31:0]       E_PC,
  input  logic [31:0]       E_Data,
  input  logic [31:0]       E_WriteMemData,
  input  logic [T_W-1:0]    E_T,
  input  logic              E_WriteRegEnable,
  input  logic [4:0]        E_RegId,
  input  logic [EXT_W-1:0]  E_ExtType,
  input  logic [3:0]        E_MemWriteEnable,
  input  logic              E_MemFamily,
  input  logic              E_MemKill,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [3:0]        data_sram_wstrb,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              dm_stall,
  output logic [31:0]       M_PC,
  output logic [T_W-1:0]    M_T,
  output logic              M_WriteRegEnable,
  output logic [4:0]        M_RegId,
  output logic [31:0]       M_Data,
  output mem_state_t        dbg_state
);

  mem_state_t       state, state_nxt, cap_state;
  logic [31:0]      m_pc, m_data, m_wmd;
  logic [T_W-1:0]   m_t;
  logic             m_wre, m_mem;
  logic [4:0]       m_rid;
  logic [EXT_W-1:0] m_ext;
  logic [3:0]       m_mwe;
  logic [31:0]      req_addr, load_res;
  logic             is_load, load_pending, load_done;

  // M pipeline register: bubble on reset/flush, else capture when not stalled.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      m_pc  <= '0; m_data <= '0; m_wmd <= '0; m_t   <= '0;
      m_wre <= 1'b0; m_rid <= '0; m_ext <= '0; m_mwe <= '0; m_mem <= 1'b0;
    end else if (exp_flush) begin
      m_pc  <= '0; m_data <= '0; m_wmd <= '0; m_t   <= '0;
      m_wre <= 1'b0; m_rid <= '0; m_ext <= '0; m_mwe <= '0; m_mem <= 1'b0;
    end else if (!dm_stall) begin
      m_pc   <= E_PC;
      m_data <= E_Data;
      m_wmd  <= E_WriteMemData;
      m_t    <= (E_T == '0) ? '0 : E_T - T_W'(1);
      m_wre  <= E_WriteRegEnable;
      m_rid  <= E_RegId;
      m_ext  <= E_ExtType;
      m_mwe  <= E_MemWriteEnable;
      m_mem  <= E_MemFamily;
    end
  end

  // Transaction FSM state register.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, request and stall. Any edge that captures a new bundle
  // (IDLE, or DATA/DRAIN on data_ok) starts its transaction straight away,
  // so back-to-back memory instructions do not lose a cycle.
  always_comb begin
    state_nxt     = state;
    data_sram_req = 1'b0;
    dm_stall      = 1'b0;
    cap_state     = (E_MemFamily & ~E_MemKill) ? ST_ADDR : ST_IDLE;
    case (state)
      ST_IDLE: begin
        state_nxt = exp_flush ? ST_IDLE : cap_state;
      end
      ST_ADDR: begin
        data_sram_req = ~exp_flush;
        dm_stall      = 1'b1;
        if (exp_flush)              state_nxt = ST_IDLE;
        else if (data_sram_addr_ok) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (data_sram_data_ok) begin
          state_nxt = exp_flush ? ST_IDLE : cap_state;
        end else begin
          dm_stall = 1'b1;
          if (exp_flush) state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (data_sram_data_ok) state_nxt = exp_flush ? ST_IDLE : cap_state;
        else                   dm_stall  = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request fields come straight from the M register, so they stay stable
  // for as long as the stage is stalled.
`ifdef MEM_UNALIGNED_LWLR_EN
  assign req_addr = (m_ext[EXT_LWL] | m_ext[EXT_LWR]) ? {m_data[31:2], 2'b00} : m_data;
`else
  assign req_addr = m_data;
`endif

  assign data_sram_wr    = |m_mwe;
  assign data_sram_wstrb = m_mwe;
  assign data_sram_wdata = m_wmd << {m_data[1:0], 3'b000};
  assign data_sram_size  = req_size(m_mwe, m_ext);
  assign data_sram_addr  = req_addr[ADDR_W-1:0];

  load_extend_unit u_load_extend (
    .rdata    (data_sram_rdata),
    .addr_lo  (m_data[1:0]),
    .ext_type (m_ext),
    .rt_old   (m_wmd),
    .result   (load_res)
  );

  // The load result is presented in the data_ok cycle itself: the M register
  // captures the next bundle on that same edge.
  assign is_load      = m_mem & ~(|m_mwe);
  assign load_done    = is_load & (state == ST_DATA) & data_sram_data_ok;
  assign load_pending = is_load & ((state == ST_ADDR) |
                                   ((state == ST_DATA) & ~data_sram_data_ok));

  assign M_PC             = m_pc;
  assign M_WriteRegEnable = m_wre;
  assign M_RegId          = m_rid;
  assign M_Data           = load_done ? load_res : m_data;
  assign M_T              = (load_pending && m_t == '0) ? T_W'(1) : m_t;
  assign dbg_state        = state;

endmodule
